// File: rtl/mips_pipeline_idex_register_pkg.sv
// Shared definitions for the ID/EX pipeline register: MIPS instruction field
// positions, the slot load-select encoding and a field extraction helper.
package mips_pipeline_idex_register_pkg;

    // Architectural MIPS register specifier width and instruction width.
    localparam int MIPS_REG_W   = 5;
    localparam int MIPS_INSTR_W = 32;

    // Least-significant bit of each register specifier inside the instruction.
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

    // The immediate occupies instr[15:0] and is sign-extended to the word width.
    localparam int IMM_W = 16;

    // Where a slot takes its next payload from.
    //   LOAD_HOLD  : keep its own contents (operands still refreshed)
    //   LOAD_INPUT : capture and decode the incoming decode-stage bundle
    //   LOAD_PEER  : copy the already-decoded contents of the other slot
    typedef enum logic [1:0] {
        LOAD_HOLD  = 2'd0,
        LOAD_INPUT = 2'd1,
        LOAD_PEER  = 2'd2
    } load_sel_e;

    // Pull a 5-bit register specifier out of a 32-bit instruction word.
    function automatic logic [MIPS_REG_W-1:0] instr_field(
        input logic [MIPS_INSTR_W-1:0] instr,
        input int                      lsb
    );
        return instr[lsb +: MIPS_REG_W];
    endfunction

endpackage

// File: rtl/mips_pipeline_idex_register_if.sv
// Bundle of every flow-controlled signal around the ID/EX register: the
// decode-side handshake and payload, flush, writeback snoop and the
// execute-side handshake and payload. The master drives decode/writeback
// and consumes the execute bundle; the slave is the pipeline register.
interface mips_pipeline_idex_register_if
    import mips_pipeline_idex_register_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 16
);
    // decode side
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_W-1:0]     in_pc;
    logic [WORD_W-1:0]     in_instr;
    logic [CTRL_W-1:0]     in_control;
    logic [WORD_W-1:0]     in_reg1;
    logic [WORD_W-1:0]     in_reg2;

    // pipeline control and writeback snoop
    logic                  flush;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [WORD_W-1:0]     wb_data;

    // execute side
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_pc;
    logic [WORD_W-1:0]     out_instr;
    logic [CTRL_W-1:0]     out_control;
    logic [WORD_W-1:0]     out_reg1;
    logic [WORD_W-1:0]     out_reg2;
    logic [WORD_W-1:0]     out_imm;
    logic [REG_ADDR_W-1:0] out_rs;
    logic [REG_ADDR_W-1:0] out_rt;
    logic [REG_ADDR_W-1:0] out_rd;

    modport master (
        output in_valid, in_pc, in_instr, in_control, in_reg1, in_reg2,
        output flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_control,
        input  out_reg1, out_reg2, out_imm, out_rs, out_rt, out_rd
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_control, in_reg1, in_reg2,
        input  flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_control,
        output out_reg1, out_reg2, out_imm, out_rs, out_rt, out_rd
    );

endinterface

// File: rtl/mips_pipeline_idex_register_entry.sv
// One ID/EX slot. Selects its next payload (hold / decode input / peer slot),
// decodes register fields and immediate on capture, and overwrites the stored
// operands whenever writeback targets the slot's rs/rt (never register 0).
// The same comparator serves capture bypass, in-place refresh and refresh of
// data moving in from the peer slot, because it always looks at the
// specifiers of whatever payload is about to be stored.
module mips_pipeline_idex_register_entry
    import mips_pipeline_idex_register_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 16
)(
    input  logic                  clk,
    input  logic                  srst,
    input  load_sel_e             i_load_sel,
    input  logic                  i_valid_next,
    // raw decode-stage bundle
    input  logic [WORD_W-1:0]     i_pc,
    input  logic [WORD_W-1:0]     i_instr,
    input  logic [CTRL_W-1:0]     i_control,
    input  logic [WORD_W-1:0]     i_reg1,
    input  logic [WORD_W-1:0]     i_reg2,
    // already-decoded contents of the peer slot
    input  logic [WORD_W-1:0]     i_peer_pc,
    input  logic [WORD_W-1:0]     i_peer_instr,
    input  logic [CTRL_W-1:0]     i_peer_control,
    input  logic [WORD_W-1:0]     i_peer_reg1,
    input  logic [WORD_W-1:0]     i_peer_reg2,
    input  logic [WORD_W-1:0]     i_peer_imm,
    input  logic [REG_ADDR_W-1:0] i_peer_rs,
    input  logic [REG_ADDR_W-1:0] i_peer_rt,
    input  logic [REG_ADDR_W-1:0] i_peer_rd,
    // writeback snoop
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [WORD_W-1:0]     i_wb_data,
    // stored contents
    output logic                  o_valid,
    output logic [WORD_W-1:0]     o_pc,
    output logic [WORD_W-1:0]     o_instr,
    output logic [CTRL_W-1:0]     o_control,
    output logic [WORD_W-1:0]     o_reg1,
    output logic [WORD_W-1:0]     o_reg2,
    output logic [WORD_W-1:0]     o_imm,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic [REG_ADDR_W-1:0] o_rd
);

    logic                  r_valid;
    logic [WORD_W-1:0]     r_pc;
    logic [WORD_W-1:0]     r_instr;
    logic [CTRL_W-1:0]     r_control;
    logic [WORD_W-1:0]     r_reg1;
    logic [WORD_W-1:0]     r_reg2;
    logic [WORD_W-1:0]     r_imm;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_rd;

    // Field decode of the incoming instruction. The word is viewed as 32 bits
    // so narrow datapaths still see the MIPS field positions (upper bits zero);
    // the size cast keeps the LSBs of a 5-bit specifier or zero-extends it.
    logic [MIPS_INSTR_W-1:0] w_in_instr32;
    logic [REG_ADDR_W-1:0]   w_in_rs;
    logic [REG_ADDR_W-1:0]   w_in_rt;
    logic [REG_ADDR_W-1:0]   w_in_rd;
    logic [WORD_W-1:0]       w_in_imm;

    assign w_in_instr32 = MIPS_INSTR_W'(i_instr);
    assign w_in_rs      = REG_ADDR_W'(instr_field(w_in_instr32, RS_LSB));
    assign w_in_rt      = REG_ADDR_W'(instr_field(w_in_instr32, RT_LSB));
    assign w_in_rd      = REG_ADDR_W'(instr_field(w_in_instr32, RD_LSB));
    assign w_in_imm     = WORD_W'($signed(i_instr[IMM_W-1:0]));

    // Payload about to be stored, before the writeback overwrite.
    logic [WORD_W-1:0]     w_src_pc;
    logic [WORD_W-1:0]     w_src_instr;
    logic [CTRL_W-1:0]     w_src_control;
    logic [WORD_W-1:0]     w_src_reg1;
    logic [WORD_W-1:0]     w_src_reg2;
    logic [WORD_W-1:0]     w_src_imm;
    logic [REG_ADDR_W-1:0] w_src_rs;
    logic [REG_ADDR_W-1:0] w_src_rt;
    logic [REG_ADDR_W-1:0] w_src_rd;

    logic                  w_hit1;
    logic                  w_hit2;
    logic [WORD_W-1:0]     w_reg1_next;
    logic [WORD_W-1:0]     w_reg2_next;

    // Load mux followed by the writeback match on the selected specifiers.
    always_comb begin
        w_src_pc      = r_pc;
        w_src_instr   = r_instr;
        w_src_control = r_control;
        w_src_reg1    = r_reg1;
        w_src_reg2    = r_reg2;
        w_src_imm     = r_imm;
        w_src_rs      = r_rs;
        w_src_rt      = r_rt;
        w_src_rd      = r_rd;
        unique case (i_load_sel)
            LOAD_INPUT: begin
                w_src_pc      = i_pc;
                w_src_instr   = i_instr;
                w_src_control = i_control;
                w_src_reg1    = i_reg1;
                w_src_reg2    = i_reg2;
                w_src_imm     = w_in_imm;
                w_src_rs      = w_in_rs;
                w_src_rt      = w_in_rt;
                w_src_rd      = w_in_rd;
            end
            LOAD_PEER: begin
                w_src_pc      = i_peer_pc;
                w_src_instr   = i_peer_instr;
                w_src_control = i_peer_control;
                w_src_reg1    = i_peer_reg1;
                w_src_reg2    = i_peer_reg2;
                w_src_imm     = i_peer_imm;
                w_src_rs      = i_peer_rs;
                w_src_rt      = i_peer_rt;
                w_src_rd      = i_peer_rd;
            end
            default: begin
            end
        endcase

        w_hit1      = i_wb_en && (i_wb_addr != '0) && (i_wb_addr == w_src_rs);
        w_hit2      = i_wb_en && (i_wb_addr != '0) && (i_wb_addr == w_src_rt);
        w_reg1_next = w_hit1 ? i_wb_data : w_src_reg1;
        w_reg2_next = w_hit2 ? i_wb_data : w_src_reg2;
    end

    // Slot storage; everything clears on reset so outputs never show X.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_control <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
        end else begin
            r_valid   <= i_valid_next;
            r_pc      <= w_src_pc;
            r_instr   <= w_src_instr;
            r_control <= w_src_control;
            r_reg1    <= w_reg1_next;
            r_reg2    <= w_reg2_next;
            r_imm     <= w_src_imm;
            r_rs      <= w_src_rs;
            r_rt      <= w_src_rt;
            r_rd      <= w_src_rd;
        end
    end

    assign o_valid   = r_valid;
    assign o_pc      = r_pc;
    assign o_instr   = r_instr;
    assign o_control = r_control;
    assign o_reg1    = r_reg1;
    assign o_reg2    = r_reg2;
    assign o_imm     = r_imm;
    assign o_rs      = r_rs;
    assign o_rt      = r_rt;
    assign o_rd      = r_rd;

endmodule

// File: rtl/mips_pipeline_idex_register.sv
// ID/EX pipeline register. Main slot M always drives execute. With SKID=1 a
// second slot S absorbs one bundle while M is stalled so in_ready can come
// straight from a flop; with SKID=0 in_ready is combinational on out_ready.
module mips_pipeline_idex_register
    import mips_pipeline_idex_register_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 16,
    parameter int SKID       = 1
)(
    input  logic                          clk,
    input  logic                          srst,
    mips_pipeline_idex_register_if.slave  bus
);

    logic      w_in_ready;
    logic      w_accept;
    logic      w_consume;

    load_sel_e w_m_sel;
    logic      w_m_valid_next;
    logic      w_m_valid;

    // Skid slot contents, also the peer source for M.
    logic                  w_s_valid;
    logic [WORD_W-1:0]     w_s_pc;
    logic [WORD_W-1:0]     w_s_instr;
    logic [CTRL_W-1:0]     w_s_control;
    logic [WORD_W-1:0]     w_s_reg1;
    logic [WORD_W-1:0]     w_s_reg2;
    logic [WORD_W-1:0]     w_s_imm;
    logic [REG_ADDR_W-1:0] w_s_rs;
    logic [REG_ADDR_W-1:0] w_s_rt;
    logic [REG_ADDR_W-1:0] w_s_rd;

    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_consume     = w_m_valid & bus.out_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_m_valid;

    mips_pipeline_idex_register_entry #(
        .WORD_W     (WORD_W),
        .REG_ADDR_W (REG_ADDR_W),
        .CTRL_W     (CTRL_W)
    ) u_main (
        .clk            (clk),
        .srst           (srst),
        .i_load_sel     (w_m_sel),
        .i_valid_next   (w_m_valid_next),
        .i_pc           (bus.in_pc),
        .i_instr        (bus.in_instr),
        .i_control      (bus.in_control),
        .i_reg1         (bus.in_reg1),
        .i_reg2         (bus.in_reg2),
        .i_peer_pc      (w_s_pc),
        .i_peer_instr   (w_s_instr),
        .i_peer_control (w_s_control),
        .i_peer_reg1    (w_s_reg1),
        .i_peer_reg2    (w_s_reg2),
        .i_peer_imm     (w_s_imm),
        .i_peer_rs      (w_s_rs),
        .i_peer_rt      (w_s_rt),
        .i_peer_rd      (w_s_rd),
        .i_wb_en        (bus.wb_en),
        .i_wb_addr      (bus.wb_addr),
        .i_wb_data      (bus.wb_data),
        .o_valid        (w_m_valid),
        .o_pc           (bus.out_pc),
        .o_instr        (bus.out_instr),
        .o_control      (bus.out_control),
        .o_reg1         (bus.out_reg1),
        .o_reg2         (bus.out_reg2),
        .o_imm          (bus.out_imm),
        .o_rs           (bus.out_rs),
        .o_rt           (bus.out_rt),
        .o_rd           (bus.out_rd)
    );

    generate
        if (SKID != 0) begin : g_skid
            load_sel_e w_s_sel;
            logic      w_s_valid_next;
            logic      r_in_ready;

            // Slot steering: refill M from S first, else from the input;
            // park the input in S only while M is stalled. Flush wins.
            always_comb begin
                w_m_sel        = LOAD_HOLD;
                w_m_valid_next = w_m_valid;
                w_s_sel        = LOAD_HOLD;
                w_s_valid_next = w_s_valid;
                if (bus.flush) begin
                    w_m_valid_next = 1'b0;
                    w_s_valid_next = 1'b0;
                end else if (!w_m_valid || w_consume) begin
                    if (w_s_valid) begin
                        // in_ready is low whenever S is full, so no accept here
                        w_m_sel        = LOAD_PEER;
                        w_m_valid_next = 1'b1;
                        w_s_valid_next = 1'b0;
                    end else begin
                        w_m_valid_next = w_accept;
                        if (w_accept) begin
                            w_m_sel = LOAD_INPUT;
                        end
                    end
                end else if (w_accept) begin
                    w_s_sel        = LOAD_INPUT;
                    w_s_valid_next = 1'b1;
                end
            end

            // Registered ready: open exactly when S will be empty next cycle.
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_in_ready <= 1'b0;
                end else begin
                    r_in_ready <= ~w_s_valid_next;
                end
            end

            assign w_in_ready = r_in_ready;

            mips_pipeline_idex_register_entry #(
                .WORD_W     (WORD_W),
                .REG_ADDR_W (REG_ADDR_W),
                .CTRL_W     (CTRL_W)
            ) u_skid (
                .clk            (clk),
                .srst           (srst),
                .i_load_sel     (w_s_sel),
                .i_valid_next   (w_s_valid_next),
                .i_pc           (bus.in_pc),
                .i_instr        (bus.in_instr),
                .i_control      (bus.in_control),
                .i_reg1         (bus.in_reg1),
                .i_reg2         (bus.in_reg2),
                .i_peer_pc      ('0),
                .i_peer_instr   ('0),
                .i_peer_control ('0),
                .i_peer_reg1    ('0),
                .i_peer_reg2    ('0),
                .i_peer_imm     ('0),
                .i_peer_rs      ('0),
                .i_peer_rt      ('0),
                .i_peer_rd      ('0),
                .i_wb_en        (bus.wb_en),
                .i_wb_addr      (bus.wb_addr),
                .i_wb_data      (bus.wb_data),
                .o_valid        (w_s_valid),
                .o_pc           (w_s_pc),
                .o_instr        (w_s_instr),
                .o_control      (w_s_control),
                .o_reg1         (w_s_reg1),
                .o_reg2         (w_s_reg2),
                .o_imm          (w_s_imm),
                .o_rs           (w_s_rs),
                .o_rt           (w_s_rt),
                .o_rd           (w_s_rd)
            );
        end else begin : g_single
            logic r_started;

            // Keeps in_ready low through reset and the first cycle after it.
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_started <= 1'b0;
                end else begin
                    r_started <= 1'b1;
                end
            end

            assign w_in_ready = r_started & (~w_m_valid | bus.out_ready);

            // Single slot: capture on accept, empty on consume, flush wins.
            always_comb begin
                w_m_sel        = LOAD_HOLD;
                w_m_valid_next = w_m_valid;
                if (bus.flush) begin
                    w_m_valid_next = 1'b0;
                end else if (w_accept) begin
                    w_m_sel        = LOAD_INPUT;
                    w_m_valid_next = 1'b1;
                end else if (w_consume) begin
                    w_m_valid_next = 1'b0;
                end
            end

            assign w_s_valid   = 1'b0;
            assign w_s_pc      = '0;
            assign w_s_instr   = '0;
            assign w_s_control = '0;
            assign w_s_reg1    = '0;
            assign w_s_reg2    = '0;
            assign w_s_imm     = '0;
            assign w_s_rs      = '0;
            assign w_s_rt      = '0;
            assign w_s_rd      = '0;
        end
    endgenerate

endmodule
